// File: rtl/fetch_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | fetch_unit_pkg : shared state encoding and constants for the fetch unit    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_TRAP  = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_INCR    = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// +----------------------------------------------------------------------------+
// | fetch_buffer : small {pc, instr} FIFO between fetch and decode, with flush |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [DATA_W-1:0]     i_instr,
  output logic [ADDR_W-1:0]     o_pc,
  output logic [DATA_W-1:0]     o_instr,
  output logic [FIFO_CNT_W-1:0] o_count
);

  logic [ADDR_W-1:0]     r_pc_mem    [FIFO_DEPTH];
  logic [DATA_W-1:0]     r_instr_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] r_wr_ptr;
  logic [FIFO_PTR_W-1:0] r_rd_ptr;
  logic [FIFO_CNT_W-1:0] r_count;
  logic [FIFO_PTR_W-1:0] w_wr_ptr_nxt;
  logic [FIFO_PTR_W-1:0] w_rd_ptr_nxt;

  assign w_wr_ptr_nxt = (r_wr_ptr == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + FIFO_PTR_W'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + FIFO_PTR_W'(1);

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_pc_mem[r_wr_ptr]    <= i_pc;
      r_instr_mem[r_wr_ptr] <= i_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (i_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
        2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pc    = r_pc_mem[r_rd_ptr];
  assign o_instr = r_instr_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------------+
// | fetch_unit : PC sequencer feeding a 2-deep instruction buffer to decode.   |
// | Option macro FETCH_MISALIGN_TRAP_EN: trap on misaligned redirect targets.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned NUMBER_OF_ADDRESS_BITS = 10,
  parameter int unsigned NUMBER_OF_DATA_BITS    = 32,
  parameter int unsigned RESET_PC               = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic [NUMBER_OF_ADDRESS_BITS-1:0] rom_addr,
  input  logic [NUMBER_OF_DATA_BITS-1:0]    rom_data,
  input  logic                              redirect_valid,
  input  logic [NUMBER_OF_ADDRESS_BITS-1:0] redirect_pc,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUMBER_OF_DATA_BITS-1:0]    out_instr,
  output logic [NUMBER_OF_ADDRESS_BITS-1:0] out_pc,
  output logic                              fetch_fault,
  output logic [NUMBER_OF_ADDRESS_BITS-1:0] fault_pc
);

  localparam int unsigned AW = NUMBER_OF_ADDRESS_BITS;
  localparam int unsigned DW = NUMBER_OF_DATA_BITS;

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [AW-1:0]         r_pc;
  logic [AW-1:0]         w_pc_nxt;
  logic [AW-1:0]         w_target;
  logic                  w_misaligned;
  logic                  w_push;
  logic                  w_pop;
  logic [FIFO_CNT_W-1:0] w_count;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign w_target     = redirect_pc;
`else
  assign w_misaligned = 1'b0;
  assign w_target     = redirect_pc & ~AW'(PC_INCR - 1);
`endif

  assign w_pop = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    if (redirect_valid) begin
      w_pc_nxt    = w_target;
      w_state_nxt = w_misaligned ? ST_TRAP : ST_FETCH;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_FETCH;
        ST_FETCH: begin
          // A pop this cycle frees a slot, so a full buffer can still stream.
          if ((w_count < FIFO_CNT_W'(FIFO_DEPTH)) || w_pop) begin
            w_push   = 1'b1;
            w_pc_nxt = r_pc + AW'(PC_INCR);
          end
        end
        ST_TRAP:  w_state_nxt = ST_TRAP;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= AW'(RESET_PC);
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  fetch_buffer #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_fetch_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop & ~redirect_valid),
    .i_flush (redirect_valid),
    .i_pc    (r_pc),
    .i_instr (rom_data),
    .o_pc    (out_pc),
    .o_instr (out_instr),
    .o_count (w_count)
  );

  assign rom_addr  = r_pc;
  assign out_valid = (w_count != '0);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic          r_fetch_fault;
  logic [AW-1:0] r_fault_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_fault <= 1'b0;
      r_fault_pc    <= '0;
    end else if (redirect_valid) begin
      r_fetch_fault <= w_misaligned;
      r_fault_pc    <= w_misaligned ? redirect_pc : '0;
    end
  end

  assign fetch_fault = r_fetch_fault;
  assign fault_pc    = r_fault_pc;
`else
  assign fetch_fault = 1'b0;
  assign fault_pc    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
`default_nettype none

module tb_fetch_unit;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int PC_SPACE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          fetch_fault;
  logic [AW-1:0] fault_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .NUMBER_OF_ADDRESS_BITS (AW),
    .NUMBER_OF_DATA_BITS    (DW),
    .RESET_PC               (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
  );

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ {a[15:0], 16'hC3A5};
  endfunction

  always_comb rom_data = rom_fn({22'd0, rom_addr});

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = waiting after reset, 1 = streaming, 2 = trapped.
  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  ent_t          m_q[$];
  int            m_pc;
  int            m_mode;
  logic          m_fault;
  logic [AW-1:0] m_fpc;

  task automatic model_reset();
    m_q.delete();
    m_pc    = 0;
    m_mode  = 0;
    m_fault = 1'b0;
    m_fpc   = '0;
  endtask

  task automatic model_step(input bit redir, input int rpc, input bit ready);
    bit pop;
    ent_t e;
    pop = (m_q.size() > 0) && ready;
    if (redir) begin
      m_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc % 4 != 0) begin
        m_mode = 2; m_fault = 1'b1; m_fpc = AW'(rpc); m_pc = rpc;
      end else begin
        m_mode = 1; m_fault = 1'b0; m_fpc = '0; m_pc = rpc;
      end
`else
      m_pc   = rpc - (rpc % 4);
      m_mode = 1;
`endif
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (pop) void'(m_q.pop_front());
      if (m_q.size() < 2) begin
        e.pc    = AW'(m_pc);
        e.instr = rom_fn(m_pc);
        m_q.push_back(e);
        m_pc = (m_pc + 4) % PC_SPACE;
      end
    end
  endtask

  task automatic check_all();
    chk("rom_addr", rom_addr, m_pc);
    chk("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_instr", out_instr, m_q[0].instr);
    end
    chk("fetch_fault", fetch_fault, m_fault);
    chk("fault_pc", fault_pc, m_fpc);
  endtask

  task automatic cycle(input bit redir, input int rpc, input bit ready);
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = AW'(rpc);
    out_ready      = ready;
    check_all();
    model_step(redir, rpc, ready);
  endtask

  task automatic do_reset(input bit ready);
    rst_n = 1'b0;
    model_reset();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = ready;
    repeat (2) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
    model_step(1'b0, 0, ready);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r;
    int rpc;
    bit redir;
    bit rdy;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;

    // Boot sequence with decode always ready.
    do_reset(1'b1);
    chk("reset_rom_addr", rom_addr, 'h000);
    chk("reset_valid", out_valid, 0);
    cycle(0, 0, 1);
    chk("boot_c1_valid", out_valid, 0);
    cycle(0, 0, 1);
    chk("boot_pc0", out_pc, 'h000);
    chk("boot_i0", out_instr, rom_fn(32'h0));
    cycle(0, 0, 1);
    chk("boot_pc1", out_pc, 'h004);
    chk("boot_i1", out_instr, rom_fn(32'h4));
    cycle(0, 0, 1);
    chk("boot_pc2", out_pc, 'h008);
    chk("boot_i2", out_instr, rom_fn(32'h8));

    // Backpressure from reset: buffer fills with 0x000/0x004, PC parks at 0x008.
    do_reset(1'b0);
    repeat (6) cycle(0, 0, 0);
    chk("stall_rom_addr", rom_addr, 'h008);
    chk("stall_valid", out_valid, 1);
    chk("stall_head", out_pc, 'h000);
    repeat (6) cycle(0, 0, 1);

    // Redirect while full.
    repeat (4) cycle(0, 0, 0);
    cycle(1, 'h100, 0);
    cycle(0, 0, 0);
    chk("redir_valid", out_valid, 0);
    chk("redir_rom_addr", rom_addr, 'h100);
    cycle(0, 0, 0);
    chk("redir_out_pc", out_pc, 'h100);

    // PC wrap at the top of the address space.
    cycle(1, 'h3F8, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("wrap_pc_3f8", out_pc, 'h3F8);
    cycle(0, 0, 1);
    chk("wrap_pc_3fc", out_pc, 'h3FC);
    cycle(0, 0, 1);
    chk("wrap_pc_000", out_pc, 'h000);

    // Misaligned redirect.
    cycle(1, 'h102, 1);
    cycle(0, 0, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault", fetch_fault, 1);
    chk("mis_fault_pc", fault_pc, 'h102);
    chk("mis_valid", out_valid, 0);
    cycle(0, 0, 1);
    chk("mis_valid_hold", out_valid, 0);
`else
    chk("mis_fault", fetch_fault, 0);
    chk("mis_rom_addr", rom_addr, 'h100);
    cycle(0, 0, 1);
    chk("mis_out_pc", out_pc, 'h100);
`endif
    cycle(1, 'h040, 1);
    cycle(0, 0, 1);
    chk("realign_fault", fetch_fault, 0);
    chk("realign_fault_pc", fault_pc, 'h000);
    cycle(0, 0, 1);
    chk("realign_out_pc", out_pc, 'h040);

    // Asynchronous reset while the buffer is full.
    repeat (3) cycle(0, 0, 0);
    chk("pre_areset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_rom_addr", rom_addr, 'h000);
    do_reset(1'b1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("restart_pc", out_pc, 'h000);

    // Randomized traffic.
    repeat (3000) begin
      r     = $urandom_range(0, 99);
      redir = (r < 6);
      if ($urandom_range(0, 4) == 0) rpc = $urandom_range(0, PC_SPACE - 1);
      else                           rpc = $urandom_range(0, PC_SPACE / 4 - 1) * 4;
      rdy = ($urandom_range(0, 3) != 0);
      cycle(redir, rpc, rdy);
    end
    cycle(0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
